// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: owns the fetch PC and buffers fetched words in a small FIFO
// ahead of the IF/ID register; a redirect flushes the FIFO and re-steers fetch.
module if_prefetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    output logic                     imem_req,
    input  logic [31:0]              imem_instr,
    input  logic                     redirect,
    input  logic [31:0]              redirect_target,
    input  logic                     deq_en,
    output logic                     if_valid,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_instr,
    output logic [31:0]              if_pc_next,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_fetch_pc;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;

    assign w_empty = (r_count == '0);
    assign w_pop   = deq_en && !w_empty && !redirect;
    // Gating with reset keeps imem_req low and blocks memory writes while in reset.
    assign w_push  = reset && !redirect && (r_count < FULL || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= {redirect_target[31:2], 2'b00};
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= imem_instr;
        end
    end

    assign imem_addr  = r_fetch_pc;
    assign imem_req   = w_push;
    assign count      = r_count;
    assign if_valid   = !w_empty;
    assign if_pc      = w_empty ? 32'd0 : r_pc_mem[r_rd_ptr];
    assign if_instr   = w_empty ? NOP_INSTR : r_instr_mem[r_rd_ptr];
    assign if_pc_next = if_pc + 32'd4;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed stimulus with a scoreboard of expected
// {pc, instr} pairs checked by a monitor whenever the head is consumed.
module tb_if_prefetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        deq_en;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_next;
    logic [2:0]  count;
    logic [31:0] mask;
    logic [63:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    assign imem_instr = imem_addr ^ mask;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_instr(imem_instr), .redirect(redirect), .redirect_target(redirect_target),
        .deq_en(deq_en), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_pc_next(if_pc_next), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A head entry is consumed on the edge following a negedge where deq_en is seen.
    always @(negedge clk) begin
        if (reset && !redirect && deq_en && if_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h with no expected entry", if_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", if_pc, e[63:32]);
                chk("sb_instr", if_instr, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; deq_en = 1'b0; redirect = 1'b0; redirect_target = '0; mask = '0;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 32'h13);
        chk("rst_pc_next", if_pc_next, 4);
        chk("rst_addr", imem_addr, 0);
        chk("rst_req", 32'(imem_req), 0);
        // fill with no dequeue
        @(posedge clk); #1 reset = 1'b1;
        #1 chk("release_req", 32'(imem_req), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_count", 32'(count), 4);
        chk("full_req", 32'(imem_req), 0);
        chk("full_addr", imem_addr, 16);
        chk("full_head_pc", if_pc, 0);
        chk("full_head_instr", if_instr, 0);
        chk("full_pc_next", if_pc_next, 4);
        @(negedge clk);
        chk("full_addr_hold", imem_addr, 16);
        // single pop while full
        exp_q.push_back({32'd0, 32'd0});
        @(posedge clk); #1 deq_en = 1'b1;
        @(negedge clk);
        chk("fullpop_req", 32'(imem_req), 1);
        @(posedge clk); #1 deq_en = 1'b0;
        chk("fullpop_count", 32'(count), 4);
        chk("fullpop_head", if_pc, 4);
        chk("fullpop_addr", imem_addr, 20);
        // streaming from a fresh reset
        @(posedge clk); #1 reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_addr", imem_addr, 0);
        chk("async_valid", 32'(if_valid), 0);
        mask = 32'hDEAD_0000;
        for (int k = 0; k < 8; k++) exp_q.push_back({32'(4 * k), 32'hDEAD_0000 | 32'(4 * k)});
        @(posedge clk); #1 reset = 1'b1; deq_en = 1'b1;
        @(negedge clk);
        chk("stream_valid0", 32'(if_valid), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("stream_count", 32'(count), 1);
            chk("stream_pc", if_pc, 32'(4 * k));
        end
        @(posedge clk); #1 deq_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("pre_redirect_count", 32'(count), 3);
        // redirect with a simultaneous dequeue request
        redirect = 1'b1; redirect_target = 32'h43; deq_en = 1'b1;
        @(posedge clk); #1 redirect = 1'b0; deq_en = 1'b0; redirect_target = '0;
        @(negedge clk);
        chk("redir_count", 32'(count), 0);
        chk("redir_valid", 32'(if_valid), 0);
        chk("redir_instr", if_instr, 32'h13);
        chk("redir_addr", imem_addr, 32'h40);
        @(negedge clk);
        chk("redir_head_pc", if_pc, 32'h40);
        chk("redir_pc_next", if_pc_next, 32'h44);
        chk("redir_head_instr", if_instr, 32'hDEAD_0040);
        @(negedge clk);
        chk("pre_reset_count", 32'(count), 2);
        // asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(if_valid), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_req", 32'(imem_req), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("restart_req", 32'(imem_req), 1);
        @(negedge clk);
        chk("restart_pc", if_pc, 0);
        chk("restart_instr", if_instr, 32'hDEAD_0000);
        chk("restart_count", 32'(count), 1);
        // redirect to the top of the address space and wrap
        @(posedge clk); #1 redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
        exp_q.push_back({32'hFFFF_FFFC, 32'h2152_FFFC});
        exp_q.push_back({32'h0000_0000, 32'hDEAD_0000});
        exp_q.push_back({32'h0000_0004, 32'hDEAD_0004});
        @(posedge clk); #1 redirect = 1'b0; deq_en = 1'b1;
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_count0", 32'(count), 0);
        @(negedge clk);
        chk("wrap_head", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_next", if_pc_next, 0);
        @(negedge clk);
        chk("wrap_head_zero", if_pc, 0);
        @(negedge clk);
        @(posedge clk); #1 deq_en = 1'b0;
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 0);
        chk("end_count", 32'(count), 1);
        chk("end_head", if_pc, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
